// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two valid/ready writeback sources queued in FIFOs, fixed-priority onto one regfile write port
// Define REGFILE_WARB_AGE_EN to force a grant to B after STARVE_LIMIT consecutive losses.
module regfile_write_arbiter #(
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk_port,
    input  logic        rst_port,
    input  logic        a_valid,
    output logic        a_ready,
    input  logic [4:0]  a_address,
    input  logic [31:0] a_data,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_address,
    input  logic [31:0] b_data,
    output logic [31:0] data_d,
    output logic [4:0]  address_d,
    output logic        wr,
    output logic        idle
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_param
        $error("regfile_write_arbiter: bad DEPTH or STARVE_LIMIT");
    end

    logic [36:0]   mem_a [DEPTH];
    logic [36:0]   mem_b [DEPTH];
    logic [AW-1:0] wp_a, rp_a, wp_b, rp_b;
    logic [AW:0]   cnt_a, cnt_b;
    logic          push_a, push_b, ne_a, ne_b, force_b, grant_a, grant_b;
    logic [36:0]   head;

    always_comb begin
        a_ready = cnt_a != FULL;
        b_ready = cnt_b != FULL;
        push_a  = a_valid & a_ready;
        push_b  = b_valid & b_ready;
        ne_a    = cnt_a != '0;
        ne_b    = cnt_b != '0;
        grant_a = ne_a & !force_b;
        grant_b = ne_b & !grant_a;
        head    = grant_a ? mem_a[rp_a] : mem_b[rp_b];
        idle    = !ne_a & !ne_b & !wr;
    end

`ifdef REGFILE_WARB_AGE_EN
    logic [3:0] starve;
    assign force_b = ne_b && starve == 4'(STARVE_LIMIT);
    // counts consecutive cycles B waits with an entry; any B grant or empty B restarts it
    always_ff @(posedge clk_port or posedge rst_port)
        if (rst_port) starve <= '0;
        else starve <= (!ne_b || grant_b) ? 4'd0 : starve + 4'd1;
`else
    assign force_b = 1'b0;
`endif

    always_ff @(posedge clk_port) begin
        if (push_a) mem_a[wp_a] <= {a_address, a_data};
        if (push_b) mem_b[wp_b] <= {b_address, b_data};
    end

    always_ff @(posedge clk_port or posedge rst_port)
        if (rst_port) begin
            wp_a      <= '0;
            rp_a      <= '0;
            wp_b      <= '0;
            rp_b      <= '0;
            cnt_a     <= '0;
            cnt_b     <= '0;
            wr        <= 1'b0;
            data_d    <= '0;
            address_d <= '0;
        end else begin
            if (push_a) wp_a <= wp_a + 1'b1;
            if (push_b) wp_b <= wp_b + 1'b1;
            if (grant_a) rp_a <= rp_a + 1'b1;
            if (grant_b) rp_b <= rp_b + 1'b1;
            cnt_a <= cnt_a + (AW+1)'(push_a) - (AW+1)'(grant_a);
            cnt_b <= cnt_b + (AW+1)'(push_b) - (AW+1)'(grant_b);
            // register 0 is hardwired, so its writes are popped but never strobed
            wr    <= (grant_a | grant_b) && head[36:32] != 5'd0;
            if (grant_a | grant_b) {address_d, data_d} <= head;
        end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed vector table plus multi-cycle sequences for full, starvation and reset.
module tb_regfile_write_arbiter;
    logic        clk_port = 1'b0, rst_port = 1'b1;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic [4:0]  a_address = '0, b_address = '0;
    logic [31:0] a_data = '0, b_data = '0;
    logic        a_ready, b_ready, wr, idle;
    logic [31:0] data_d;
    logic [4:0]  address_d;

    int tests = 0, fails = 0, cyc = 0;

    typedef struct {
        logic        av;
        logic [4:0]  aa;
        logic [31:0] ad;
        logic        bv;
        logic [4:0]  ba;
        logic [31:0] bd;
        logic        e_wr;
        logic [4:0]  e_addr;
        logic [31:0] e_data;
        logic        e_ar;
        logic        e_br;
        logic        e_idle;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        int          c;
    } commit_t;

    vec_t    vecs [13];
    commit_t log_q [$];

    regfile_write_arbiter dut (
        .clk_port(clk_port), .rst_port(rst_port),
        .a_valid(a_valid), .a_ready(a_ready), .a_address(a_address), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_address(b_address), .b_data(b_data),
        .data_d(data_d), .address_d(address_d), .wr(wr), .idle(idle)
    );

    always #5 clk_port = ~clk_port;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        commit_t e;
        @(posedge clk_port);
        #1;
        cyc++;
        if (wr) begin
            e.addr = address_d;
            e.data = data_d;
            e.c    = cyc;
            log_q.push_back(e);
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                         input logic bv, input logic [4:0] ba, input logic [31:0] bd);
        a_valid = av; a_address = aa; a_data = ad;
        b_valid = bv; b_address = ba; b_data = bd;
    endtask

    task automatic drain(input string name);
        for (int k = 0; k < 40 && !idle; k++) tick();
        check(name, 64'(idle), 64'd1);
    endtask

    function automatic logic [63:0] outs();
        return 64'({wr, address_d, data_d, a_ready, b_ready, idle});
    endfunction

    initial begin
        int ls, n, bc, got;
        logic [31:0] bdat [$];
        vecs[0]  = '{1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 32'h0,        1, 1, 0};
        vecs[1]  = '{0, 0, 0,            0, 0, 0,            1, 5, 32'hDEADBEEF, 1, 1, 0};
        vecs[2]  = '{0, 0, 0,            0, 0, 0,            0, 5, 32'hDEADBEEF, 1, 1, 1};
        vecs[3]  = '{0, 0, 0,            1, 0, 32'h12345678, 0, 5, 32'hDEADBEEF, 1, 1, 0};
        vecs[4]  = '{0, 0, 0,            0, 0, 0,            0, 0, 32'h12345678, 1, 1, 1};
        vecs[5]  = '{1, 1, 32'h11,       1, 2, 32'h22,       0, 0, 32'h12345678, 1, 1, 0};
        vecs[6]  = '{0, 0, 0,            0, 0, 0,            1, 1, 32'h11,       1, 1, 0};
        vecs[7]  = '{0, 0, 0,            0, 0, 0,            1, 2, 32'h22,       1, 1, 0};
        vecs[8]  = '{0, 0, 0,            0, 0, 0,            0, 2, 32'h22,       1, 1, 1};
        vecs[9]  = '{1, 7, 32'hAA,       1, 7, 32'hBB,       0, 2, 32'h22,       1, 1, 0};
        vecs[10] = '{0, 0, 0,            0, 0, 0,            1, 7, 32'hAA,       1, 1, 0};
        vecs[11] = '{0, 0, 0,            0, 0, 0,            1, 7, 32'hBB,       1, 1, 0};
        vecs[12] = '{0, 0, 0,            0, 0, 0,            0, 7, 32'hBB,       1, 1, 1};

        #12 rst_port = 1'b0;
        #1 check("reset_state", outs(), 64'({1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1}));

        for (int i = 0; i < 13; i++) begin
            drive(vecs[i].av, vecs[i].aa, vecs[i].ad, vecs[i].bv, vecs[i].ba, vecs[i].bd);
            tick();
            check($sformatf("vec%0d", i), outs(),
                  64'({vecs[i].e_wr, vecs[i].e_addr, vecs[i].e_data, vecs[i].e_ar, vecs[i].e_br, vecs[i].e_idle}));
        end

        // asynchronous reset while a write is on the port
        drive(1, 9, 32'h99, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("pre_reset_write", outs(), 64'({1'b1, 5'd9, 32'h99, 1'b1, 1'b1, 1'b0}));
        #3 rst_port = 1'b1;
        #1 check("async_reset", outs(), 64'({1'b0, 5'd0, 32'd0, 1'b1, 1'b1, 1'b1}));
        #2 rst_port = 1'b0;

        // fill B while A keeps the port busy
        ls = log_q.size();
        for (int i = 0; i < 4; i++) begin
            drive(1, 5'(10 + i), 32'hA0 + 32'(i), 1, 5'(20 + i), 32'(i + 1));
            tick();
        end
        check("b_full_ready", 64'(b_ready), 64'd0);
        check("a_ready_stream", 64'(a_ready), 64'd1);
        drive(1, 14, 32'hA4, 1, 24, 32'd5);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drain("full_drain");
        bc = 0;
        for (int i = ls; i < log_q.size(); i++)
            if (log_q[i].addr >= 20) begin
                bc++;
                bdat.push_back(log_q[i].data);
            end
        check("full_b_commits", 64'(bc), 64'd4);
        for (int i = 0; i < bdat.size() && i < 4; i++)
            check($sformatf("full_order%0d", i), 64'(bdat[i]), 64'(i + 1));

        // B queued against a continuous A stream
        ls = log_q.size();
        drive(1, 10, 32'h100, 1, 25, 32'hBB);
        tick();
        n = cyc;
        for (int i = 1; i < 8; i++) begin
            drive(1, 10, 32'h100 + 32'(i), 0, 0, 0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        drain("starve_drain");
        got = -1;
        for (int i = ls; i < log_q.size(); i++)
            if (log_q[i].addr == 5'd25) got = log_q[i].c - n;
`ifdef REGFILE_WARB_AGE_EN
        check("starve_b_slot", 64'(got), 64'd4);
`else
        check("starve_b_slot", 64'(got), 64'd9);
`endif

        // reset discards queued writes
        drive(1, 11, 32'd1, 1, 12, 32'd2);
        tick();
        drive(1, 13, 32'd3, 1, 14, 32'd4);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("midstream_busy", 64'(idle), 64'd0);
        #3 rst_port = 1'b1;
        #1 check("midstream_reset_idle", 64'(idle), 64'd1);
        #2 rst_port = 1'b0;
        n = log_q.size();
        repeat (10) tick();
        check("midstream_no_wr", 64'(log_q.size() - n), 64'd0);
        check("midstream_idle", 64'(idle), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
